// File: rtl/module_ifm_win3x3_gen_x8.sv
// 3x3 sliding-window generator for an 8-channel int4 raster stream.
// Two line buffers plus a two-column shift window feed one registered lane per channel.

module ifm_win3x3_lane (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [8:0][3:0] nib,
   output logic [35:0]     win
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    win <= '0;
      else if (load) win <= nib;
   end
endmodule

module module_ifm_win3x3_gen_x8 #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] din,
   input  logic        din_valid,
   input  logic        din_sof,
   output logic        din_ready,
   output logic [35:0] ifm_win3x3_0,
   output logic [35:0] ifm_win3x3_1,
   output logic [35:0] ifm_win3x3_2,
   output logic [35:0] ifm_win3x3_3,
   output logic [35:0] ifm_win3x3_4,
   output logic [35:0] ifm_win3x3_5,
   output logic [35:0] ifm_win3x3_6,
   output logic [35:0] ifm_win3x3_7,
   output logic        win_valid,
   output logic        win_first,
   output logic        win_last,
   output logic        frame_done
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   col, cur_col;
   logic [RW-1:0]   row, cur_row;
   logic            accept, pos_zero, col_end, row_end, frame_end, win_hit;
   logic [31:0]     lb0 [IMG_W];
   logic [31:0]     lb1 [IMG_W];
   logic [31:0]     lb0_rd, lb1_rd;
   logic [2:0][31:0] sh1, sh2;
   logic [8:0][31:0] pix;
   logic [7:0][35:0] win_ch;

   assign accept    = din_valid & din_ready;
   // A sof pixel, or the first pixel after IDLE, is always (0,0).
   assign pos_zero  = din_sof | (state == S_IDLE);
   assign cur_col   = pos_zero ? '0 : col;
   assign cur_row   = pos_zero ? '0 : row;
   assign col_end   = (cur_col == CW'(IMG_W - 1));
   assign row_end   = (cur_row == RW'(IMG_H - 1));
   assign frame_end = col_end & row_end;
   assign win_hit   = accept & (cur_row >= RW'(2)) & (cur_col >= CW'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      din_ready  = 1'b1;
      frame_done = 1'b0;
      case (state)
         S_IDLE: if (accept) state_nxt = S_FILL;
         S_FILL: if (accept && cur_row == RW'(2) && cur_col == '0) state_nxt = S_RUN;
         S_RUN: begin
            if (accept) begin
               if (din_sof)        state_nxt = S_FILL;
               else if (frame_end) state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            din_ready  = 1'b0;
            frame_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (state == S_DONE) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         col <= col_end ? '0 : cur_col + CW'(1);
         if (col_end) row <= row_end ? '0 : cur_row + RW'(1);
         else         row <= cur_row;
      end
   end

   assign lb0_rd = lb0[cur_col];
   assign lb1_rd = lb1[cur_col];

   // Storage only; stale contents never reach a window because win_hit needs row>=2, col>=2.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[cur_col] <= lb0_rd;
         lb0[cur_col] <= din;
         sh2 <= sh1;
         sh1 <= {din, lb0_rd, lb1_rd};
      end
   end

   // Row-major, index 0 = (r-2,c-2), index 8 = the pixel being accepted.
   assign pix[0] = sh2[0];
   assign pix[1] = sh1[0];
   assign pix[2] = lb1_rd;
   assign pix[3] = sh2[1];
   assign pix[4] = sh1[1];
   assign pix[5] = lb0_rd;
   assign pix[6] = sh2[2];
   assign pix[7] = sh1[2];
   assign pix[8] = din;

   for (genvar g = 0; g < 8; g++) begin : g_lane
      logic [8:0][3:0] nib;
      always_comb begin
         for (int k = 0; k < 9; k++) nib[k] = pix[k][4*g +: 4];
      end
      ifm_win3x3_lane u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (win_hit),
         .nib   (nib),
         .win   (win_ch[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid <= 1'b0;
         win_first <= 1'b0;
         win_last  <= 1'b0;
      end else begin
         win_valid <= win_hit;
         win_first <= win_hit & (cur_row == RW'(2)) & (cur_col == CW'(2));
         win_last  <= win_hit & frame_end;
      end
   end

   assign ifm_win3x3_0 = win_ch[0];
   assign ifm_win3x3_1 = win_ch[1];
   assign ifm_win3x3_2 = win_ch[2];
   assign ifm_win3x3_3 = win_ch[3];
   assign ifm_win3x3_4 = win_ch[4];
   assign ifm_win3x3_5 = win_ch[5];
   assign ifm_win3x3_6 = win_ch[6];
   assign ifm_win3x3_7 = win_ch[7];
endmodule

// File: tb/tb_module_ifm_win3x3_gen_x8.sv
// Directed bench: small 5x4 instance for the protocol scenarios, 28x28 instance for a random frame.

module tb_module_ifm_win3x3_gen_x8;
   localparam int W = 5, H = 4, BW = 28, BH = 28;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] din = '0;
   logic        din_valid = 1'b0, din_sof = 1'b0, din_ready;
   logic [35:0] sw [8];
   logic        win_valid, win_first, win_last, frame_done;

   logic [31:0] bdin = '0;
   logic        bvalid = 1'b0, bsof = 1'b0, bready;
   logic [35:0] bw [8];
   logic        bwin_valid, bwin_first, bwin_last, bframe_done;

   module_ifm_win3x3_gen_x8 #(.IMG_W(W), .IMG_H(H)) u_dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sof(din_sof),
      .din_ready(din_ready),
      .ifm_win3x3_0(sw[0]), .ifm_win3x3_1(sw[1]), .ifm_win3x3_2(sw[2]), .ifm_win3x3_3(sw[3]),
      .ifm_win3x3_4(sw[4]), .ifm_win3x3_5(sw[5]), .ifm_win3x3_6(sw[6]), .ifm_win3x3_7(sw[7]),
      .win_valid(win_valid), .win_first(win_first), .win_last(win_last), .frame_done(frame_done)
   );

   module_ifm_win3x3_gen_x8 #(.IMG_W(BW), .IMG_H(BH)) u_big (
      .clk(clk), .rst_n(rst_n), .din(bdin), .din_valid(bvalid), .din_sof(bsof),
      .din_ready(bready),
      .ifm_win3x3_0(bw[0]), .ifm_win3x3_1(bw[1]), .ifm_win3x3_2(bw[2]), .ifm_win3x3_3(bw[3]),
      .ifm_win3x3_4(bw[4]), .ifm_win3x3_5(bw[5]), .ifm_win3x3_6(bw[6]), .ifm_win3x3_7(bw[7]),
      .win_valid(bwin_valid), .win_first(bwin_first), .win_last(bwin_last), .frame_done(bframe_done)
   );

   int checks = 0, failures = 0;
   int nwin, nbad, nfd, nrdy_low, nfirst, first_at, last_at;
   logic [35:0] first_ch0;
   logic [31:0] img [BH][BW];

   function automatic logic [31:0] pat(int r, int c);
      logic [31:0] p;
      logic [3:0]  b;
      b = 4'((5*r + c) % 16);
      for (int ch = 0; ch < 8; ch++) p[4*ch +: 4] = b ^ 4'(ch);
      return p;
   endfunction

   function automatic logic [35:0] exp_win(int r, int c, int ch);
      logic [35:0] w;
      logic [31:0] p;
      for (int k = 0; k < 9; k++) begin
         p = pat(r - 2 + k/3, c - 2 + k%3);
         w[4*k +: 4] = p[4*ch +: 4];
      end
      return w;
   endfunction

   task automatic clear_counts();
      nwin = 0; nbad = 0; nfd = 0; nrdy_low = 0; nfirst = 0; first_at = 0; last_at = 0;
      first_ch0 = '0;
   endtask

   // Tallies what the small DUT shows after one edge; tests compare the tallies.
   task automatic sample_small(input bit exp_v, input int r, input int c);
      if (frame_done) nfd++;
      if (win_valid !== exp_v) nbad++;
      else if (exp_v) begin
         nwin++;
         if (win_first) begin nfirst++; first_at = nwin; first_ch0 = sw[0]; end
         if (win_last) last_at = nwin;
         if (win_first !== (r == 2 && c == 2)) nbad++;
         if (win_last !== (r == H-1 && c == W-1)) nbad++;
         for (int ch = 0; ch < 8; ch++) if (sw[ch] !== exp_win(r, c, ch)) nbad++;
      end else if (win_first || win_last) nbad++;
   endtask

   task automatic run_frame(input bit sof, input bit gap, input int npix, input int tail);
      int r, c, guard;
      for (int i = 0; i < npix; i++) begin
         r = i / W; c = i % W;
         guard = 0;
         while (din_ready !== 1'b1 && guard < 10) begin
            din_valid = 1'b0;
            nrdy_low++;
            @(posedge clk); #1;
            sample_small(1'b0, 0, 0);
            guard++;
         end
         if (guard >= 10) nbad++;
         din = pat(r, c); din_sof = sof && (i == 0); din_valid = 1'b1;
         @(posedge clk); #1;
         din_valid = 1'b0; din_sof = 1'b0;
         sample_small(r >= 2 && c >= 2, r, c);
         if (gap) begin @(posedge clk); #1; sample_small(1'b0, 0, 0); end
      end
      for (int t = 0; t < tail; t++) begin
         if (din_ready !== 1'b1) nrdy_low++;
         @(posedge clk); #1;
         sample_small(1'b0, 0, 0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
      checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
      checks++; if ({win_first, win_last} !== 2'b00) begin failures++; $display("FAIL reset_first_last got=%b exp=00", {win_first, win_last}); end
      for (int ch = 0; ch < 8; ch++) begin
         checks++; if (sw[ch] !== 36'd0) begin failures++; $display("FAIL reset_win ch%0d got=%h exp=0", ch, sw[ch]); end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      clear_counts();
      run_frame(1'b1, 1'b0, W*H, 3);
      checks++; if (nwin !== 6) begin failures++; $display("FAIL basic_nwin got=%0d exp=6", nwin); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL basic_bad got=%0d exp=0", nbad); end
      checks++; if (first_ch0 !== 36'hCBA765210) begin failures++; $display("FAIL basic_first_ch0 got=%h exp=cba765210", first_ch0); end
      checks++; if (first_at !== 1) begin failures++; $display("FAIL basic_first_at got=%0d exp=1", first_at); end
      checks++; if (last_at !== 6) begin failures++; $display("FAIL basic_last_at got=%0d exp=6", last_at); end
      checks++; if (nfd !== 1) begin failures++; $display("FAIL basic_frame_done got=%0d exp=1", nfd); end
   endtask

   task automatic test_gaps();
      clear_counts();
      run_frame(1'b1, 1'b1, W*H, 2);
      checks++; if (nwin !== 6) begin failures++; $display("FAIL gaps_nwin got=%0d exp=6", nwin); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL gaps_bad got=%0d exp=0", nbad); end
      checks++; if (nfd !== 1) begin failures++; $display("FAIL gaps_frame_done got=%0d exp=1", nfd); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      run_frame(1'b1, 1'b0, W*H, 0);
      run_frame(1'b1, 1'b0, W*H, 3);
      checks++; if (nwin !== 12) begin failures++; $display("FAIL b2b_nwin got=%0d exp=12", nwin); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL b2b_bad got=%0d exp=0", nbad); end
      checks++; if (nfd !== 2) begin failures++; $display("FAIL b2b_frame_done got=%0d exp=2", nfd); end
      checks++; if (nrdy_low !== 2) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=2", nrdy_low); end
      checks++; if (nfirst !== 2) begin failures++; $display("FAIL b2b_first got=%0d exp=2", nfirst); end
   endtask

   task automatic test_sof_restart();
      clear_counts();
      run_frame(1'b1, 1'b0, 2*W + 3, 0);
      checks++; if (nwin !== 1) begin failures++; $display("FAIL sof_partial_nwin got=%0d exp=1", nwin); end
      nwin = 0; nfirst = 0;
      run_frame(1'b1, 1'b0, W*H, 3);
      checks++; if (nwin !== 6) begin failures++; $display("FAIL sof_nwin got=%0d exp=6", nwin); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL sof_bad got=%0d exp=0", nbad); end
      checks++; if (nfd !== 1) begin failures++; $display("FAIL sof_frame_done got=%0d exp=1", nfd); end
      checks++; if (nfirst !== 1) begin failures++; $display("FAIL sof_first got=%0d exp=1", nfirst); end
   endtask

   task automatic test_reset_mid();
      clear_counts();
      run_frame(1'b1, 1'b0, 3*W + 1, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL rstmid_win_valid got=%b exp=0", win_valid); end
      checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL rstmid_din_ready got=%b exp=1", din_ready); end
      checks++; if (sw[3] !== 36'd0) begin failures++; $display("FAIL rstmid_win ch3 got=%h exp=0", sw[3]); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_counts();
      run_frame(1'b0, 1'b0, W*H, 3);
      checks++; if (nwin !== 6) begin failures++; $display("FAIL rstmid_nwin got=%0d exp=6", nwin); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL rstmid_bad got=%0d exp=0", nbad); end
      checks++; if (nfd !== 1) begin failures++; $display("FAIL rstmid_frame_done got=%0d exp=1", nfd); end
   endtask

   task automatic test_random();
      logic [35:0] w;
      logic [31:0] p;
      int bwin = 0, bbad = 0, bfd = 0, bfirst = 0, blast = 0;
      for (int r = 0; r < BH; r++)
         for (int c = 0; c < BW; c++) img[r][c] = $urandom;
      for (int r = 0; r < BH; r++) begin
         for (int c = 0; c < BW; c++) begin
            bdin = img[r][c]; bsof = (r == 0 && c == 0); bvalid = 1'b1;
            @(posedge clk); #1;
            bvalid = 1'b0; bsof = 1'b0;
            if (bframe_done) bfd++;
            if (bwin_valid !== (r >= 2 && c >= 2)) bbad++;
            else if (bwin_valid) begin
               bwin++;
               if (bwin_first) bfirst++;
               if (bwin_last) blast++;
               if (bwin_first !== (r == 2 && c == 2)) bbad++;
               if (bwin_last !== (r == BH-1 && c == BW-1)) bbad++;
               for (int ch = 0; ch < 8; ch++) begin
                  for (int k = 0; k < 9; k++) begin
                     p = img[r - 2 + k/3][c - 2 + k%3];
                     w[4*k +: 4] = p[4*ch +: 4];
                  end
                  if (bw[ch] !== w) bbad++;
               end
            end
         end
      end
      repeat (2) begin @(posedge clk); #1; if (bframe_done) bfd++; end
      checks++; if (bwin !== 676) begin failures++; $display("FAIL rand_nwin got=%0d exp=676", bwin); end
      checks++; if (bbad !== 0) begin failures++; $display("FAIL rand_bad got=%0d exp=0", bbad); end
      checks++; if (bfd !== 1) begin failures++; $display("FAIL rand_frame_done got=%0d exp=1", bfd); end
      checks++; if ({bfirst, blast} !== {32'd1, 32'd1}) begin failures++; $display("FAIL rand_first_last got=%0d/%0d exp=1/1", bfirst, blast); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_back_to_back();
      test_sof_restart();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
